// File: rtl/hash_pe_request_batch_serializer_if.sv
// Request-vector in / request-beat out handshake bundle for the hash PE
// batch serializer.
//   input_*  : one vector of IN_W request slots plus head address and delim
//   output_* : one beat of up to OUT_LANES requests plus delim
// Modports: master = producer/consumer environment, slave = serializer.
interface hash_pe_request_batch_serializer_if #(
    parameter int unsigned IN_W      = 8,
    parameter int unsigned OUT_LANES = 2,
    parameter int unsigned HASH_W    = 13,
    parameter int unsigned ADDR_W    = 32
);
    logic                        input_valid;
    logic [ADDR_W-1:0]           input_head_addr;
    logic [IN_W-1:0]             input_mask_vec;
    logic [IN_W*HASH_W-1:0]      input_hash_value_vec;
    logic                        input_delim;
    logic                        input_ready;

    logic                        output_valid;
    logic [OUT_LANES-1:0]        output_lane_mask;
    logic [OUT_LANES*ADDR_W-1:0] output_addr_vec;
    logic [OUT_LANES*HASH_W-1:0] output_hash_value_vec;
    logic                        output_delim;
    logic                        output_ready;

    modport master (
        output input_valid, input_head_addr, input_mask_vec,
               input_hash_value_vec, input_delim, output_ready,
        input  input_ready, output_valid, output_lane_mask,
               output_addr_vec, output_hash_value_vec, output_delim
    );

    modport slave (
        input  input_valid, input_head_addr, input_mask_vec,
               input_hash_value_vec, input_delim, output_ready,
        output input_ready, output_valid, output_lane_mask,
               output_addr_vec, output_hash_value_vec, output_delim
    );
endinterface

// File: rtl/hash_pe_request_batch_serializer.sv
// Hash PE request batch serializer.
// Accepts a vector of IN_W masked request slots, caps the number kept per
// vector, and emits the kept slots lowest-index first, OUT_LANES per beat.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   cfg_max_queued_req_num   : per-vector cap (0 = IN_W), sampled on accept
//   bus (slave)              : input vector / output beat handshakes
//   drop_count               : saturating count of requests removed by the cap
module hash_pe_request_batch_serializer #(
    parameter int unsigned IN_W      = 8,
    parameter int unsigned OUT_LANES = 2,
    parameter int unsigned HASH_W    = 13,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned CNT_W     = $clog2(IN_W) + 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [CNT_W-1:0]                   cfg_max_queued_req_num,
    hash_pe_request_batch_serializer_if.slave  bus,
    output logic [15:0]                        drop_count
);
    typedef enum logic {IDLE, DRAIN} state_t;
    state_t state;

    // Buffered vector; buf_rem holds kept slots not yet placed on a beat.
    logic [ADDR_W-1:0]           buf_head;
    logic [IN_W*HASH_W-1:0]      buf_hash;
    logic                        buf_delim;
    logic [IN_W-1:0]             buf_rem;

    logic                        accept;
    logic                        fire;
    logic                        last;

    logic [IN_W-1:0]             kept;
    logic [16:0]                 n_drop;
    logic [16:0]                 drop_sum;
    int unsigned                 cap;
    int unsigned                 n_req;
    int unsigned                 n_kept;

    logic [IN_W-1:0]             src_mask;
    logic [ADDR_W-1:0]           src_head;
    logic [IN_W*HASH_W-1:0]      src_hash;
    logic                        src_delim;
    logic                        beat_exists;

    logic [OUT_LANES-1:0]        nb_mask;
    logic [OUT_LANES*ADDR_W-1:0] nb_addr;
    logic [OUT_LANES*HASH_W-1:0] nb_hash;
    logic [IN_W-1:0]             nb_rem;
    logic                        nb_delim;
    int unsigned                 rank;

    // The output registers always hold the current beat, so the beat is last
    // exactly when nothing is left behind it in buf_rem.
    assign fire   = bus.output_valid && bus.output_ready;
    assign last   = (buf_rem == '0);
    assign bus.input_ready = !rst && ((state == IDLE) || (last && bus.output_ready));
    assign accept = bus.input_valid && bus.input_ready;

    // Keep the lowest-index set bits up to the cap.
    always_comb begin
        if (cfg_max_queued_req_num == '0 || 32'(cfg_max_queued_req_num) > IN_W)
            cap = IN_W;
        else
            cap = 32'(cfg_max_queued_req_num);
        kept   = '0;
        n_req  = 0;
        n_kept = 0;
        for (int unsigned i = 0; i < IN_W; i++) begin
            if (bus.input_mask_vec[i]) begin
                n_req++;
                if (n_kept < cap) begin
                    kept[i] = 1'b1;
                    n_kept++;
                end
            end
        end
        n_drop   = 17'(n_req - n_kept);
        drop_sum = {1'b0, drop_count} + n_drop;
    end

    // The next beat comes from the incoming vector on accept, otherwise from
    // the remainder of the buffered one.
    assign src_mask    = accept ? kept : buf_rem;
    assign src_head    = accept ? bus.input_head_addr : buf_head;
    assign src_hash    = accept ? bus.input_hash_value_vec : buf_hash;
    assign src_delim   = accept ? bus.input_delim : buf_delim;
    // An empty delimited vector still needs one (empty) beat to carry delim.
    assign beat_exists = (src_mask != '0) || (accept && src_delim);

    always_comb begin
        nb_mask = '0;
        nb_addr = '0;
        nb_hash = '0;
        nb_rem  = src_mask;
        rank    = 0;
        for (int unsigned i = 0; i < IN_W; i++) begin
            if (src_mask[i]) begin
                for (int unsigned j = 0; j < OUT_LANES; j++) begin
                    if (rank == j) begin
                        nb_mask[j]                     = 1'b1;
                        nb_addr[j*ADDR_W +: ADDR_W]    = src_head + ADDR_W'(i);
                        nb_hash[j*HASH_W +: HASH_W]    = src_hash[i*HASH_W +: HASH_W];
                        nb_rem[i]                      = 1'b0;
                    end
                end
                rank++;
            end
        end
        nb_delim = src_delim && (nb_rem == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state                 <= IDLE;
            buf_rem               <= '0;
            bus.output_valid      <= 1'b0;
            bus.output_lane_mask  <= '0;
            bus.output_delim      <= 1'b0;
            drop_count            <= '0;
        end else begin
            if (accept) begin
                buf_head   <= bus.input_head_addr;
                buf_hash   <= bus.input_hash_value_vec;
                buf_delim  <= bus.input_delim;
                drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            end
            if (accept || fire) begin
                if (beat_exists) begin
                    state                     <= DRAIN;
                    buf_rem                   <= nb_rem;
                    bus.output_valid          <= 1'b1;
                    bus.output_lane_mask      <= nb_mask;
                    bus.output_addr_vec       <= nb_addr;
                    bus.output_hash_value_vec <= nb_hash;
                    bus.output_delim          <= nb_delim;
                end else begin
                    state                <= IDLE;
                    buf_rem              <= '0;
                    bus.output_valid     <= 1'b0;
                    bus.output_lane_mask <= '0;
                    bus.output_delim     <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_hash_pe_request_batch_serializer.sv
module tb_hash_pe_request_batch_serializer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  cfg = '0;
    logic [15:0] drop_count;

    always #5 clk = ~clk;

    hash_pe_request_batch_serializer_if #(
        .IN_W(8), .OUT_LANES(2), .HASH_W(13), .ADDR_W(32)
    ) bus ();

    hash_pe_request_batch_serializer #(
        .IN_W(8), .OUT_LANES(2), .HASH_W(13), .ADDR_W(32), .CNT_W(4)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .cfg_max_queued_req_num (cfg),
        .bus                    (bus),
        .drop_count             (drop_count)
    );

    typedef struct {
        logic [1:0]  lm;
        logic [31:0] a0;
        logic [12:0] h0;
        logic [31:0] a1;
        logic [12:0] h1;
        logic        d;
    } beat_t;

    beat_t q[$];
    int    pop_cyc[$];
    int    checks = 0;
    int    errors = 0;
    int    n_pop  = 0;
    int    cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic exp_beat(input logic [1:0] lm, input int a0, input int h0,
                            input int a1, input int h1, input logic d);
        beat_t b;
        b.lm = lm; b.a0 = 32'(a0); b.h0 = 13'(h0);
        b.a1 = 32'(a1); b.h1 = 13'(h1); b.d = d;
        q.push_back(b);
    endtask

    // Scoreboard monitor: compares every consumed beat with the queue head.
    always @(negedge clk) begin
        if (!rst && bus.output_valid && bus.output_ready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got lane_mask %0b with empty scoreboard",
                         bus.output_lane_mask);
            end else begin
                beat_t e;
                e = q.pop_front();
                chk("lane_mask", 64'(bus.output_lane_mask), 64'(e.lm));
                chk("delim", 64'(bus.output_delim), 64'(e.d));
                if (e.lm[0]) begin
                    chk("addr0", 64'(bus.output_addr_vec[31:0]), 64'(e.a0));
                    chk("hash0", 64'(bus.output_hash_value_vec[12:0]), 64'(e.h0));
                end
                if (e.lm[1]) begin
                    chk("addr1", 64'(bus.output_addr_vec[63:32]), 64'(e.a1));
                    chk("hash1", 64'(bus.output_hash_value_vec[25:13]), 64'(e.h1));
                end
            end
            n_pop++;
            pop_cyc.push_back(cyc);
        end
    end

    // Slot i carries hash 16*i+3. Called and returns at posedge+1.
    task automatic send(input logic [3:0] c, input int head, input logic [7:0] mask,
                        input logic d);
        logic acc;
        cfg = c;
        bus.input_head_addr = 32'(head);
        bus.input_mask_vec  = mask;
        bus.input_delim     = d;
        for (int i = 0; i < 8; i++)
            bus.input_hash_value_vec[i*13 +: 13] = 13'(16 * i + 3);
        bus.input_valid = 1'b1;
        acc = 1'b0;
        for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge clk);
            acc = bus.input_ready;
            @(posedge clk);
            #1;
        end
        bus.input_valid = 1'b0;
        if (!acc) chk("accept_timeout", 64'(acc), 64'd1);
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 200; k++) begin
            @(posedge clk);
            if (q.size() == 0) break;
        end
        #1;
        chk("scoreboard_empty", 64'(q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        bus.input_valid = 1'b0;
        bus.input_head_addr = '0;
        bus.input_mask_vec = '0;
        bus.input_hash_value_vec = '0;
        bus.input_delim = 1'b0;
        bus.output_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 64'(bus.output_valid), 64'd0);
        chk("rst_lane_mask", 64'(bus.output_lane_mask), 64'd0);
        chk("rst_delim", 64'(bus.output_delim), 64'd0);
        chk("rst_in_ready", 64'(bus.input_ready), 64'd0);
        chk("rst_drop", 64'(drop_count), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 64'(bus.input_ready), 64'd1);
        @(posedge clk);
        #1;

        // Uncapped vector, three beats
        exp_beat(2'b11, 101, 19, 102, 35, 1'b0);
        exp_beat(2'b11, 104, 67, 105, 83, 1'b0);
        exp_beat(2'b01, 107, 115, 0, 0, 1'b1);
        send(4'd0, 100, 8'b1011_0110, 1'b1);
        wait_drain();
        chk("drop_uncapped", 64'(drop_count), 64'd0);

        // Cap of 3 drops two requests
        exp_beat(2'b11, 101, 19, 102, 35, 1'b0);
        exp_beat(2'b01, 104, 67, 0, 0, 1'b1);
        send(4'd3, 100, 8'b1011_0110, 1'b1);
        wait_drain();
        chk("drop_capped", 64'(drop_count), 64'd2);

        // Back-to-back vectors without a bubble
        base = n_pop;
        exp_beat(2'b11, 200, 3, 201, 19, 1'b0);
        exp_beat(2'b11, 202, 35, 203, 51, 1'b1);
        exp_beat(2'b11, 306, 99, 307, 115, 1'b0);
        send(4'd0, 200, 8'b0000_1111, 1'b1);
        send(4'd0, 300, 8'b1100_0000, 1'b0);
        wait_drain();
        if (pop_cyc.size() >= base + 3) begin
            chk("b2b_gap_a", 64'(pop_cyc[base+1] - pop_cyc[base]), 64'd1);
            chk("b2b_gap_ab", 64'(pop_cyc[base+2] - pop_cyc[base+1]), 64'd1);
        end else begin
            chk("b2b_beats", 64'(pop_cyc.size() - base), 64'd3);
        end

        // Back-pressure mid-vector
        exp_beat(2'b11, 0, 3, 1, 19, 1'b0);
        exp_beat(2'b11, 2, 35, 3, 51, 1'b0);
        exp_beat(2'b11, 4, 67, 5, 83, 1'b0);
        exp_beat(2'b11, 6, 99, 7, 115, 1'b1);
        send(4'd0, 0, 8'hFF, 1'b1);
        @(posedge clk);
        #1;
        bus.output_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_valid", 64'(bus.output_valid), 64'd1);
            chk("stall_lane_mask", 64'(bus.output_lane_mask), 64'd3);
            chk("stall_addr", 64'(bus.output_addr_vec), {32'd3, 32'd2});
            chk("stall_hash", 64'(bus.output_hash_value_vec), 64'({13'd51, 13'd35}));
            chk("stall_delim", 64'(bus.output_delim), 64'd0);
            chk("stall_in_ready", 64'(bus.input_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        bus.output_ready = 1'b1;
        wait_drain();

        // Empty vectors
        exp_beat(2'b00, 0, 0, 0, 0, 1'b1);
        send(4'd0, 500, 8'h00, 1'b1);
        wait_drain();
        base = n_pop;
        send(4'd0, 600, 8'h00, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("empty_nodelim_valid", 64'(bus.output_valid), 64'd0);
            chk("empty_nodelim_in_ready", 64'(bus.input_ready), 64'd1);
        end
        chk("empty_nodelim_beats", 64'(n_pop - base), 64'd0);
        @(posedge clk);
        #1;

        // Reset during the second beat
        base = n_pop;
        exp_beat(2'b11, 101, 19, 102, 35, 1'b0);
        send(4'd0, 100, 8'b1011_0110, 1'b1);
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            if (n_pop > base) break;
        end
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_valid", 64'(bus.output_valid), 64'd0);
        chk("midrst_drop", 64'(drop_count), 64'd0);
        chk("midrst_in_ready", 64'(bus.input_ready), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_post_in_ready", 64'(bus.input_ready), 64'd1);
        chk("midrst_post_valid", 64'(bus.output_valid), 64'd0);
        @(posedge clk);
        #1;
        exp_beat(2'b11, 101, 19, 102, 35, 1'b0);
        exp_beat(2'b11, 104, 67, 105, 83, 1'b0);
        exp_beat(2'b01, 107, 115, 0, 0, 1'b1);
        send(4'd0, 100, 8'b1011_0110, 1'b1);
        wait_drain();
        chk("final_drop", 64'(drop_count), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hash_pe_request_batch_serializer.md
HASH_PE_REQUEST_BATCH_SERIALIZER -- requirements
Module: hash_pe_request_batch_serializer

Interface
REQ-001 Parameter IN_W, default 8: request slots per input vector.
REQ-002 Parameter OUT_LANES, default 2: maximum requests emitted per output beat, 1 <= OUT_LANES <= IN_W.
REQ-003 Parameter HASH_W, default 13: hash value width per slot.
REQ-004 Parameter ADDR_W, default 32: address width.
REQ-005 Parameter CNT_W, default $clog2(IN_W)+1: width of the cap and count fields.
REQ-006 clk  in  1  the single clock; all state updates on its rising edge.
REQ-007 rst  in  1  reset, synchronous and active-high.
REQ-008 cfg_max_queued_req_num  in  CNT_W  per-vector cap on issued requests; 0 means no cap (IN_W).
REQ-009 input_valid  in  1  input vector valid.
REQ-010 input_head_addr  in  ADDR_W  address of slot 0.
REQ-011 input_mask_vec  in  IN_W  per-slot request valid.
REQ-012 input_hash_value_vec  in  IN_W*HASH_W  slot i at bits [i*HASH_W +: HASH_W].
REQ-013 input_delim  in  1  end-of-block marker for this vector.
REQ-014 input_ready  out  1  vector accepted when input_valid && input_ready.
REQ-015 output_valid  out  1  output beat valid.
REQ-016 output_lane_mask  out  OUT_LANES  lane valid; set lanes are contiguous from lane 0.
REQ-017 output_addr_vec  out  OUT_LANES*ADDR_W  per-lane address.
REQ-018 output_hash_value_vec  out  OUT_LANES*HASH_W  per-lane hash.
REQ-019 output_delim  out  1  beat is the last beat of a delimited vector.
REQ-020 output_ready  in  1  beat consumed when output_valid && output_ready.
REQ-021 drop_count  out  16  saturating count of requests discarded by the cap.

Function
REQ-022 The FSM SHALL have two states: IDLE (buffer empty) and DRAIN (buffer holds one vector).
REQ-023 On acceptance, the block SHALL latch head_addr, the hashes and delim, and a kept mask.
REQ-024 The kept mask SHALL contain the lowest-index min(popcount(mask), Q) set bits, where Q = cfg (IN_W if cfg==0, saturated at IN_W); cfg is sampled only at acceptance.
REQ-025 drop_count SHALL increment by popcount(mask) minus popcount(kept), saturating at 16'hFFFF, in the acceptance cycle.
REQ-026 In DRAIN, each beat SHALL carry the lowest-index min(OUT_LANES, popcount(kept)) kept slots in ascending order on lanes 0..n-1; lane j addr = head_addr + slot index (mod 2^ADDR_W); lane j hash = that slot's hash.
REQ-027 On a consumed beat, the emitted slots SHALL be cleared from the kept mask; while output_ready=0, all outputs SHALL hold stable.
REQ-028 A beat SHALL be last when remaining kept bits <= OUT_LANES; output_delim = latched delim on the last beat only, otherwise 0.
REQ-029 Latency: a vector accepted in cycle t SHALL present its first beat in cycle t+1 (outputs registered, no input-to-output combinational path).
REQ-030 input_ready SHALL be 1 in IDLE, and in DRAIN only when the current beat is last and output_ready=1; a simultaneous accept then reloads the buffer and stays in DRAIN (zero-bubble throughput).
REQ-031 A vector with kept mask zero and delim=1 SHALL produce exactly one beat: output_valid=1, output_lane_mask=0, output_delim=1.
REQ-032 A vector with kept mask zero and delim=0 SHALL be consumed with no beat; the FSM goes to or stays in IDLE.
REQ-033 Number of beats per vector SHALL be ceil(popcount(kept)/OUT_LANES), or 1 for REQ-031.
REQ-034 DRAIN SHALL return to IDLE after the last beat is consumed unless a new vector is accepted in that cycle.

Reset
REQ-035 While rst=1: state=IDLE, buffer mask=0, output_valid=0, output_lane_mask=0, output_delim=0, input_ready=0, drop_count=0; data outputs don't-care.
REQ-036 Reset asserted mid-DRAIN SHALL discard the buffered vector without emitting any further beats or updating drop_count.
REQ-037 In the first cycle after rst deasserts, input_ready=1.

Verification
REQ-038 IN_W=8, OUT_LANES=2, cfg=0, mask=8'b1011_0110, head=100, delim=1, output_ready=1 -> beat 1 lanes {101,102}, delim=0; beat 2 lanes {104,105}, delim=0; beat 3 lane_mask=01 {107}, delim=1; drop_count unchanged.
REQ-039 Same vector with cfg=3 -> beats {101,102} then {104} with delim=1; drop_count += 2.
REQ-040 Two back-to-back vectors, output_ready=1 -> no idle cycle between the last beat of vector A and the first beat of vector B; input_ready pulses high on A's last beat.
REQ-041 output_ready held 0 for 5 cycles mid-vector -> beat outputs stable; input_ready=0; no slot lost or duplicated.
REQ-042 mask=0, delim=1 -> one beat with lane_mask=00, delim=1; mask=0, delim=0 -> no beat, input_ready stays 1.
REQ-043 rst pulse during beat 2 of REQ-038 -> output_valid=0 the next cycle; drop_count=0; a fresh vector after reset is serialized correctly.
